// File: rtl/sqrt_share_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_share_ctrl
//
// Shares a single square_q18 square-root unit between NREQ ray-sphere lanes.
// Each lane presents a signed Q18.14 discriminant and holds its req bit until
// it sees its gnt bit. The controller picks lanes round-robin and runs one
// operation at a time. For each operation it holds the sqrt unit in reset with
// a stable operand, releases it, and waits for done. It then returns the root
// tagged with the lane ID. A negative discriminant is a miss and is answered
// at once, without using the sqrt unit.
//
// Optional feature (compile-time macro): SQRT_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT cycles and answers with resp_err=1
//   undefined : WAIT waits for sqrt_done forever; resp_err is tied 0
//
// Ports
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   req         in   NREQ     per-lane request level
//   req_disc    in   NREQ*N   per-lane discriminant, lane i at [i*N +: N]
//   gnt         out  NREQ     one-hot pulse: lane's discriminant captured
//   resp_valid  out  1        pulse: resp_id/root/miss/err valid
//   resp_id     out  IDW      lane the response belongs to
//   resp_root   out  32       Q18.14 root, 0 on miss or error
//   resp_miss   out  1        discriminant was negative
//   resp_err    out  1        sqrt unit timed out
//   busy        out  1        controller not idle
//   sqrt_rst    out  1        active-high restart to square_q18.reset
//   sqrt_num    out  N        operand to square_q18.num_in
//   sqrt_done   in   1        square_q18.done
//   sqrt_root   in   32       square_q18.sq_root
// -----------------------------------------------------------------------------
module sqrt_share_ctrl #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int N       = 64,
   parameter int TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] req_disc,
   output logic [NREQ-1:0]   gnt,
   output logic              resp_valid,
   output logic [IDW-1:0]    resp_id,
   output logic [31:0]       resp_root,
   output logic              resp_miss,
   output logic              resp_err,
   output logic              busy,
   output logic              sqrt_rst,
   output logic [N-1:0]      sqrt_num,
   input  logic              sqrt_done,
   input  logic [31:0]       sqrt_root
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [1:0]      state_reg;
   logic [IDW-1:0]  rr_ptr_reg;
   logic [IDW-1:0]  sel_reg;
   logic            first_wait_reg;
   logic [NREQ-1:0] gnt_reg;
   logic            resp_valid_reg;
   logic [IDW-1:0]  resp_id_reg;
   logic [31:0]     resp_root_reg;
   logic            resp_miss_reg;
   logic            busy_reg;
   logic            sqrt_rst_reg;
   logic [N-1:0]    sqrt_num_reg;
   logic [31:0]     res_root_reg;
   logic            res_miss_reg;

`ifdef SQRT_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT + 1);
   logic [TCW-1:0]  timeout_cnt_reg;
   logic            res_err_reg;
   logic            resp_err_reg;
`endif

   // Unpack the flat discriminant bus into one entry per lane.
   logic [N-1:0] disc_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
         assign disc_arr[gi] = req_disc[gi*N +: N];
      end
   endgenerate

   // Round-robin pick: first set req bit at or after rr_ptr, wrapping.
   // The offsets are scanned from the highest down, so the smallest offset wins.
   logic [IDW-1:0] sel_next;
   logic           sel_found;
   int             scan_idx;

   always_comb begin
      sel_next  = '0;
      sel_found = 1'b0;
      scan_idx  = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_idx = int'(rr_ptr_reg) + k;
         if (scan_idx >= NREQ)
            scan_idx = scan_idx - NREQ;
         if (req[scan_idx]) begin
            sel_found = 1'b1;
            sel_next  = IDW'(scan_idx);
         end
      end
   end

   logic [N-1:0] sel_disc;
   assign sel_disc = disc_arr[sel_next];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         rr_ptr_reg     <= '0;
         sel_reg        <= '0;
         first_wait_reg <= 1'b0;
         gnt_reg        <= '0;
         resp_valid_reg <= 1'b0;
         resp_id_reg    <= '0;
         resp_root_reg  <= '0;
         resp_miss_reg  <= 1'b0;
         busy_reg       <= 1'b0;
         sqrt_rst_reg   <= 1'b1;
         sqrt_num_reg   <= '0;
         res_root_reg   <= '0;
         res_miss_reg   <= 1'b0;
`ifdef SQRT_TIMEOUT_EN
         timeout_cnt_reg <= '0;
         res_err_reg     <= 1'b0;
         resp_err_reg    <= 1'b0;
`endif
      end else begin
         gnt_reg        <= '0;
         resp_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               sqrt_rst_reg <= 1'b1;
               if (sel_found) begin
                  gnt_reg           <= '0;
                  gnt_reg[sel_next] <= 1'b1;
                  sel_reg           <= sel_next;
                  busy_reg          <= 1'b1;
`ifdef SQRT_TIMEOUT_EN
                  res_err_reg       <= 1'b0;
`endif
                  if (sel_disc[N-1]) begin
                     // Negative discriminant: answer as a miss and leave the
                     // sqrt unit in reset.
                     res_miss_reg <= 1'b1;
                     res_root_reg <= '0;
                     state_reg    <= ST_RESP;
                  end else begin
                     res_miss_reg <= 1'b0;
                     sqrt_num_reg <= sel_disc;
                     state_reg    <= ST_LOAD;
                  end
               end
            end

            ST_LOAD: begin
               // sqrt_rst has been high with the new operand for this full
               // cycle. Release the sqrt unit now.
               sqrt_rst_reg   <= 1'b0;
               first_wait_reg <= 1'b1;
`ifdef SQRT_TIMEOUT_EN
               timeout_cnt_reg <= '0;
`endif
               state_reg      <= ST_WAIT;
            end

            ST_WAIT: begin
               first_wait_reg <= 1'b0;
               // done in the first WAIT cycle may be left over from the
               // previous operation, so it is not trusted.
               if (!first_wait_reg && sqrt_done) begin
                  res_root_reg <= sqrt_root;
                  state_reg    <= ST_RESP;
               end
`ifdef SQRT_TIMEOUT_EN
               else if (timeout_cnt_reg == TCW'(TIMEOUT - 1)) begin
                  res_err_reg  <= 1'b1;
                  res_root_reg <= '0;
                  state_reg    <= ST_RESP;
               end else begin
                  timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
               end
`endif
            end

            default: begin  // ST_RESP
               resp_valid_reg <= 1'b1;
               resp_id_reg    <= sel_reg;
               resp_root_reg  <= res_root_reg;
               resp_miss_reg  <= res_miss_reg;
`ifdef SQRT_TIMEOUT_EN
               resp_err_reg   <= res_err_reg;
`endif
               rr_ptr_reg     <= (sel_reg == IDW'(NREQ - 1)) ? '0 : sel_reg + 1'b1;
               sqrt_rst_reg   <= 1'b1;
               busy_reg       <= 1'b0;
               state_reg      <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt        = gnt_reg;
   assign resp_valid = resp_valid_reg;
   assign resp_id    = resp_id_reg;
   assign resp_root  = resp_root_reg;
   assign resp_miss  = resp_miss_reg;
   assign busy       = busy_reg;
   assign sqrt_rst   = sqrt_rst_reg;
   assign sqrt_num   = sqrt_num_reg;
`ifdef SQRT_TIMEOUT_EN
   assign resp_err   = resp_err_reg;
`else
   assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqrt_share_ctrl
//
// Directed bench for sqrt_share_ctrl. A small behavioural square_q18 stand-in
// answers LAT cycles after its reset is released. It computes
// floor(sqrt(disc * 2^14)). Expected roots, lanes and latencies are constants
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_sqrt_share_ctrl;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int N       = 64;
   localparam int TIMEOUT = 16;
   localparam int LAT     = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] req_disc;
   logic [NREQ-1:0]   gnt;
   logic              resp_valid;
   logic [IDW-1:0]    resp_id;
   logic [31:0]       resp_root;
   logic              resp_miss;
   logic              resp_err;
   logic              busy;
   logic              sqrt_rst;
   logic [N-1:0]      sqrt_num;
   logic              sqrt_done;
   logic [31:0]       sqrt_root;

   always #5 clk = ~clk;

   sqrt_share_ctrl #(
      .NREQ(NREQ), .IDW(IDW), .N(N), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_disc(req_disc), .gnt(gnt),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_root(resp_root),
      .resp_miss(resp_miss), .resp_err(resp_err), .busy(busy),
      .sqrt_rst(sqrt_rst), .sqrt_num(sqrt_num), .sqrt_done(sqrt_done),
      .sqrt_root(sqrt_root)
   );

   // ---------------- sqrt unit stand-in ----------------
   function automatic logic [31:0] isqrt_q14(input logic [63:0] d);
      logic [95:0] x;
      logic [63:0] t;
      logic [31:0] r;
      x = {32'b0, d} << 14;
      r = '0;
      for (int b = 31; b >= 0; b--) begin
         t = {32'b0, (r | (32'd1 << b))};
         if ({32'b0, t * t} <= x)
            r = r | (32'd1 << b);
      end
      return r;
   endfunction

   logic        mdl_done = 1'b0;
   logic [31:0] mdl_root = '0;
   int          mdl_cnt = 0;
   logic        hold_done = 1'b0;
   logic        stale_done = 1'b0;

   always @(posedge clk) begin
      if (sqrt_rst) begin
         mdl_done <= 1'b0;
         mdl_cnt  <= 0;
      end else if (!hold_done) begin
         if (mdl_cnt == LAT) begin
            mdl_done <= 1'b1;
            mdl_root <= isqrt_q14(sqrt_num);
         end else begin
            mdl_cnt <= mdl_cnt + 1;
         end
      end
   end

   assign sqrt_done = mdl_done | stale_done;
   assign sqrt_root = mdl_root;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      else begin
         n_pass++;
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic set_disc(input int lane, input logic [63:0] v);
      req_disc[lane*N +: N] = v;
   endtask

   // Waits for a gnt pulse; lane = -1 on timeout.
   task automatic wait_gnt(output int lane);
      lane = -1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (gnt != '0) begin
            for (int i = 0; i < NREQ; i++)
               if (gnt[i]) lane = i;
            return;
         end
      end
   endtask

   // Waits for resp_valid; cycles = negedges waited, -1 on timeout.
   // extra_gnt counts gnt pulses seen while waiting.
   task automatic wait_resp(output int cycles, output int extra_gnt);
      cycles    = -1;
      extra_gnt = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (gnt != '0) extra_gnt++;
         if (resp_valid) begin
            cycles = c;
            return;
         end
      end
   endtask

   task automatic check_resp(input string tag, input int id, input logic [31:0] root,
                             input logic miss);
      int cyc, xg;
      wait_resp(cyc, xg);
      check_eq({tag, "_seen"}, 64'(cyc > 0), 64'd1);
      check_eq({tag, "_id"}, 64'(resp_id), 64'(id));
      check_eq({tag, "_root"}, 64'(resp_root), 64'(root));
      check_eq({tag, "_miss"}, 64'(resp_miss), 64'(miss));
      check_eq({tag, "_xgnt"}, 64'(xg), 64'd0);
   endtask

   logic [31:0] exp_root [4] = '{32'd16384, 32'd32768, 32'd49152, 32'd65536};

   initial begin
      int lane, cyc, xg, cnt;
      req      = '0;
      req_disc = '0;
      repeat (3) @(negedge clk);

      // ---- reset state ----
      check_eq("rst_gnt", 64'(gnt), 64'd0);
      check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_sqrt_rst", 64'(sqrt_rst), 64'd1);
      check_eq("rst_sqrt_num", sqrt_num, 64'd0);
      check_eq("rst_resp_root", 64'(resp_root), 64'd0);
      check_eq("rst_resp_err", 64'(resp_err), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- all lanes held: round robin 0,1,2,3,0 ----
      for (int i = 0; i < 4; i++)
         set_disc(i, 64'((i + 1) * (i + 1) * 16384));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(lane);
         check_eq($sformatf("rr_gnt%0d", k), 64'(lane), 64'(k % 4));
         if (k == 4) req = '0;
         check_resp($sformatf("rr_resp%0d", k), k % 4, exp_root[k % 4], 1'b0);
      end

      // ---- single lane 0, 16.0 -> 4.0, with a stale done around the load ----
      set_disc(0, 64'd262144);
      req = 4'b0001;
      wait_gnt(lane);
      check_eq("one_gnt", 64'(gnt), 64'd1);
      check_eq("one_busy", 64'(busy), 64'd1);
      req        = '0;
      stale_done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      stale_done = 1'b0;
      wait_resp(cyc, xg);
      check_eq("one_latency", 64'(cyc), 64'd5);
      check_eq("one_id", 64'(resp_id), 64'd0);
      check_eq("one_root", 64'(resp_root), 64'd65536);
      check_eq("one_miss", 64'(resp_miss), 64'd0);
      check_eq("one_xgnt", 64'(xg), 64'd0);
      @(negedge clk);
      check_eq("one_pulse", 64'(resp_valid), 64'd0);

      // ---- negative discriminant on lane 2 ----
      set_disc(2, 64'hFFFF_FFFF_FFFF_FFFF);
      req = 4'b0100;
      wait_gnt(lane);
      check_eq("neg_gnt", 64'(gnt), 64'd4);
      check_eq("neg_sqrt_rst_g", 64'(sqrt_rst), 64'd1);
      req = '0;
      @(negedge clk);
      check_eq("neg_valid", 64'(resp_valid), 64'd1);
      check_eq("neg_id", 64'(resp_id), 64'd2);
      check_eq("neg_miss", 64'(resp_miss), 64'd1);
      check_eq("neg_root", 64'(resp_root), 64'd0);
      check_eq("neg_sqrt_rst_r", 64'(sqrt_rst), 64'd1);

      // ---- wrap-around: serve lane 1 so rr_ptr=2, then req=0011 ----
      set_disc(1, 64'd65536);
      req = 4'b0010;
      wait_gnt(lane);
      req = '0;
      check_resp("pre1", 1, 32'd32768, 1'b0);
      set_disc(0, 64'd16384);
      req = 4'b0011;
      wait_gnt(lane);
      check_eq("wrap_gnt_a", 64'(lane), 64'd0);
      req[0] = 1'b0;
      check_resp("wrap_a", 0, 32'd16384, 1'b0);
      wait_gnt(lane);
      check_eq("wrap_gnt_b", 64'(lane), 64'd1);
      req = '0;
      check_resp("wrap_b", 1, 32'd32768, 1'b0);

      // ---- reset during WAIT ----
      set_disc(2, 64'd147456);
      req = 4'b0100;
      wait_gnt(lane);
      check_eq("ab_gnt", 64'(lane), 64'd2);
      req = '0;
      @(negedge clk);
      @(negedge clk);
      check_eq("ab_in_wait", 64'(sqrt_rst), 64'd0);
      rst_n = 1'b0;
      #1;
      check_eq("ab_busy", 64'(busy), 64'd0);
      check_eq("ab_sqrt_rst", 64'(sqrt_rst), 64'd1);
      check_eq("ab_sqrt_num", sqrt_num, 64'd0);
      req = 4'b0101;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid || gnt != '0) cnt++;
      end
      check_eq("ab_quiet", 64'(cnt), 64'd0);
      rst_n = 1'b1;
      wait_gnt(lane);
      check_eq("ab_first_gnt", 64'(lane), 64'd0);
      req[0] = 1'b0;
      check_resp("ab_a", 0, 32'd16384, 1'b0);
      wait_gnt(lane);
      check_eq("ab_second_gnt", 64'(lane), 64'd2);
      req = '0;
      check_resp("ab_b", 2, 32'd49152, 1'b0);

      // ---- sqrt unit never finishes ----
      hold_done = 1'b1;
      set_disc(0, 64'd262144);
      req = 4'b0001;
      wait_gnt(lane);
      req = '0;
`ifdef SQRT_TIMEOUT_EN
      wait_resp(cyc, xg);
      check_eq("to_latency", 64'(cyc), 64'd18);
      check_eq("to_err", 64'(resp_err), 64'd1);
      check_eq("to_root", 64'(resp_root), 64'd0);
      check_eq("to_miss", 64'(resp_miss), 64'd0);
      hold_done = 1'b0;
`else
      cnt = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (resp_valid || !busy) cnt++;
      end
      check_eq("to_stuck", 64'(cnt), 64'd0);
      check_eq("to_err", 64'(resp_err), 64'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      hold_done = 1'b0;
      @(negedge clk);
      check_eq("to_recover_busy", 64'(busy), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
